sequence_pattern_generator: RTL and testbench
=============================================

SEQUENCE_PATTERN_GENERATOR -- requirements
Module: sequence_pattern_generator

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, which sets the number of 4-bit entries in the input FIFO (power of two, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, which sets the width of the sent-word counter.
REQ-003 The block SHALL have one clock, clk, a 1-bit input; all state changes on the rising edge.
REQ-004 The block SHALL have rst_n, a 1-bit input: asynchronous, active-low reset.
REQ-005 in_valid, 1-bit input, SHALL indicate that in_data carries a word to send.
REQ-006 in_data, 4-bit input, SHALL carry the pattern word; bit 3 is transmitted first.
REQ-007 in_ready, 1-bit output, SHALL indicate that the FIFO can accept a word this cycle.
REQ-008 flush, 1-bit input, SHALL be a synchronous abort of all queued and in-flight words.
REQ-009 out, 1-bit registered output, SHALL carry the serial data bit.
REQ-010 out_valid, 1-bit registered output, SHALL be high while out carries a pattern bit.
REQ-011 expect_dec, 1-bit registered output, SHALL flag bit 0 of a word equal to 0111, 1001 or 1110.
REQ-012 busy, 1-bit output, SHALL be high while out_valid is high or the FIFO is non-empty.
REQ-013 sent_cnt, CNT_W-bit registered output, SHALL count fully transmitted words.

Function
REQ-014 A word SHALL be accepted on a rising edge where in_valid and in_ready are both high; in_data is pushed into the FIFO at that edge.
REQ-015 in_ready SHALL equal (FIFO not full) and (flush low); there is no bypass path around the FIFO.
REQ-016 The FSM SHALL have two states: IDLE and SHIFT, plus a 2-bit bit index idx.
REQ-017 In IDLE with the FIFO non-empty, the next edge SHALL pop the head into the shift register, set idx=3 and enter SHIFT.
REQ-018 In SHIFT, out SHALL equal shreg[idx] with out_valid=1, and idx SHALL decrement every cycle.
REQ-019 At idx=0 with the FIFO non-empty, the next edge SHALL pop the next word with idx=3, giving back-to-back words with no gap cycle.
REQ-020 At idx=0 with the FIFO empty, the next edge SHALL return the FSM to IDLE.
REQ-021 In IDLE, out and out_valid SHALL both be 0.
REQ-022 Latency: a word accepted at edge N into an empty FIFO while IDLE SHALL have bit 3 visible after edge N+1, and bits 2, 1, 0 on the following three cycles.
REQ-023 expect_dec SHALL be 1 only in the cycle bit 0 of a matching word is driven, and 0 at all other times.
REQ-024 sent_cnt SHALL increment by 1 at the edge that ends the bit-0 cycle, and wrap from 2^CNT_W-1 to 0.
REQ-025 FIFO full with the head being popped SHALL NOT accept a push in that cycle, because in_ready is 0 when full.
REQ-026 Flush SHALL empty the FIFO, force IDLE, and clear out, out_valid and expect_dec at the next edge.
REQ-027 A word interrupted by flush SHALL NOT increment sent_cnt, and sent_cnt SHALL otherwise be unchanged by flush.
REQ-028 When flush and in_valid are asserted together, flush SHALL win and the word SHALL be discarded.
REQ-029 FIFO read and write pointers SHALL be log2(DEPTH) bits wide plus a wrap bit; full and empty SHALL be decoded from the pointers.

Reset
REQ-030 Asserting rst_n low SHALL immediately, without a clock, set the FSM to IDLE, idx=3, FIFO empty, and out=0, out_valid=0, expect_dec=0, sent_cnt=0.
REQ-031 While rst_n is low, in_ready SHALL be 0 and busy SHALL be 0.
REQ-032 Reset asserted mid-word SHALL abort that word; no partial bit sequence SHALL resume after release.
REQ-033 The first accepted word after reset release SHALL obey REQ-022.

Verification
REQ-034 Single word: push 0111 at edge N -> out = 0,1,1,1 after edges N+1..N+4 with out_valid=1, expect_dec=1 only on the last bit, sent_cnt=1.
REQ-035 Back-to-back: push 1001, 1110, 0000 consecutively -> 12 contiguous valid bits 100111100000, expect_dec high after bits 4 and 8 only, sent_cnt=3.
REQ-036 Full FIFO: hold out_valid-side busy and push DEPTH+1 words -> in_ready drops after the FIFO fills, the extra word is not accepted, and all accepted words are emitted in order.
REQ-037 Flush: assert flush during bit 2 of word 1110 with 2 words queued -> out_valid=0 next cycle, busy=0, sent_cnt unchanged, and a simultaneous in_valid word is dropped.
REQ-038 Counter wrap: with CNT_W=2, send 5 words -> sent_cnt reads 1,2,3,0,1.
REQ-039 Asynchronous reset: drop rst_n mid-SHIFT between clock edges -> all outputs go to 0 immediately, and a word pushed after release emits per REQ-022.

Source files
------------

// File: rtl/sequence_pattern_generator.sv
// ============================================================================
// sequence_pattern_generator: FIFO-fed 4-bit word serializer, MSB first.
// Flags bit 0 of words 0111/1001/1110 and counts completed words.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sequence_pattern_generator #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out,
  output logic             out_valid,
  output logic             expect_dec,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    c_ptr_one = (AW+1)'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt, w_idx_m1;
  logic [3:0]  r_shreg, w_shreg_nxt;
  logic [3:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [3:0]  w_head;
  logic        w_empty, w_full, w_push, w_pop, w_done;
  logic        w_out_nxt, w_valid_nxt, w_dec_nxt;

  function automatic logic f_match(input logic [3:0] w);
    return (w == 4'b0111) || (w == 4'b1001) || (w == 4'b1110);
  endfunction

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign in_ready = ~w_full & ~flush & rst_n;
  assign w_push   = in_valid & in_ready;
  assign w_head   = r_mem[r_rptr[AW-1:0]];
  assign busy     = out_valid | ~w_empty;
  assign w_idx_m1 = r_idx - 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_out_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_dec_nxt   = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd3;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shreg_nxt = w_head;
            w_idx_nxt   = 2'd3;
            w_state_nxt = S_SHIFT;
            w_out_nxt   = w_head[3];
            w_valid_nxt = 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_idx != 2'd0) begin
            w_idx_nxt   = w_idx_m1;
            w_out_nxt   = r_shreg[w_idx_m1];
            w_valid_nxt = 1'b1;
            w_dec_nxt   = (w_idx_m1 == 2'd0) && f_match(r_shreg);
          end else begin
            w_done    = 1'b1;
            w_idx_nxt = 2'd3;
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_shreg_nxt = w_head;
              w_out_nxt   = w_head[3];
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd3;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_rptr <= r_wptr;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 2'd3;
      r_shreg    <= 4'd0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      expect_dec <= 1'b0;
      sent_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_shreg    <= w_shreg_nxt;
      out        <= w_out_nxt;
      out_valid  <= w_valid_nxt;
      expect_dec <= w_dec_nxt;
      if (w_done) sent_cnt <= sent_cnt + c_cnt_one;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sequence_pattern_generator.sv
// Directed self-checking bench for sequence_pattern_generator.
`default_nettype none

module tb_sequence_pattern_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0, flush = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready, out, out_valid, expect_dec, busy;
  logic [7:0] sent_cnt;

  logic       in_valid2 = 1'b0, flush2 = 1'b0;
  logic [3:0] in_data2 = 4'd0;
  logic       in_ready2, out2, out_valid2, expect_dec2, busy2;
  logic [1:0] sent_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequence_pattern_generator #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out(out), .out_valid(out_valid),
    .expect_dec(expect_dec), .busy(busy), .sent_cnt(sent_cnt)
  );

  sequence_pattern_generator #(.DEPTH(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .flush(flush2), .out(out2), .out_valid(out_valid2),
    .expect_dec(expect_dec2), .busy(busy2), .sent_cnt(sent_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_pat(input logic [3:0] w);
    return (w == 4'b0111) || (w == 4'b1001) || (w == 4'b1110);
  endfunction

  // Pushes npush words (first word in words[23:20]) one per cycle, then checks
  // that the first nexp of them stream out contiguously, MSB first.
  task automatic run(input string tag, input logic [23:0] words, input int npush,
                     input int nexp, input int full_at, input logic [7:0] exp_cnt);
    logic [3:0] w;
    for (int i = 0; i <= 4 * nexp; i++) begin
      in_valid = (i < npush);
      in_data  = (i < npush) ? words[23 - 4 * i -: 4] : 4'd0;
      if (i == full_at) check({tag, "_ready_full"}, {31'd0, in_ready}, 32'd0);
      step();
      if (i == 0) begin
        check({tag, "_lat_valid"}, {31'd0, out_valid}, 32'd0);
      end else begin
        w = words[23 - 4 * ((i - 1) / 4) -: 4];
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_bit"}, {31'd0, out}, {31'd0, words[23 - (i - 1)]});
        check({tag, "_dec"}, {31'd0, expect_dec},
              {31'd0, ((i - 1) % 4 == 3) && is_pat(w)});
      end
    end
    in_valid = 1'b0;
    step();
    check({tag, "_end_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_cnt"}, {24'd0, sent_cnt}, {24'd0, exp_cnt});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dec", {31'd0, expect_dec}, 32'd0);
    check("rst_cnt", {24'd0, sent_cnt}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Single matching word
    run("single", {4'b0111, 20'd0}, 1, 1, -1, 8'd1);

    // Three words back to back: 1001 1110 0000
    run("b2b", {4'b1001, 4'b1110, 4'b0000, 12'd0}, 3, 3, -1, 8'd4);

    // Fill the FIFO; the sixth word meets in_ready=0 and is withdrawn
    run("full", {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0101}, 6, 5, 5, 8'd9);

    // Flush during bit 2 of 1110 with two words queued, alongside a new word
    in_valid = 1'b1; in_data = 4'b1110; step();
    in_data = 4'b0011; step();
    check("flush_bit3", {31'd0, out}, 32'd1);
    in_data = 4'b0101; step();
    check("flush_bit2", {31'd0, out}, 32'd1);
    check("flush_bit2_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; in_data = 4'b1010;
    #1;
    check("flush_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out", {31'd0, out}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_cnt", {24'd0, sent_cnt}, 32'd9);
    step();
    step();
    check("flush_drop_valid", {31'd0, out_valid}, 32'd0);
    check("flush_drop_busy", {31'd0, busy}, 32'd0);

    // Counter wrap on the CNT_W=2 instance
    for (int i = 0; i <= 21; i++) begin
      in_valid2 = (i < 5);
      in_data2  = 4'b1100;
      step();
      if (i >= 5 && (i - 5) % 4 == 0)
        check("wrap_cnt", {30'd0, sent_cnt2}, 32'((((i - 5) / 4) + 1) % 4));
    end
    in_valid2 = 1'b0;

    // Asynchronous reset between edges, mid-word
    in_valid = 1'b1; in_data = 4'b1001; step();
    in_valid = 1'b0; step(); step();
    check("ares_pre_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ares_out", {31'd0, out}, 32'd0);
    check("ares_valid", {31'd0, out_valid}, 32'd0);
    check("ares_dec", {31'd0, expect_dec}, 32'd0);
    check("ares_cnt", {24'd0, sent_cnt}, 32'd0);
    check("ares_ready", {31'd0, in_ready}, 32'd0);
    check("ares_busy", {31'd0, busy}, 32'd0);
    step();
    #3 rst_n = 1'b1;
    step();
    check("ares_no_resume", {31'd0, out_valid}, 32'd0);
    run("after_rst", {4'b0111, 20'd0}, 1, 1, -1, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
